// File: rtl/cond_unit_if.sv
// Execute-stage bundle between the decoder/ALU side and the condition unit.
// The master drives instruction controls and ALU flags; the slave returns the gated strobes and stored flags.
interface cond_unit_if;
  logic       Valid;
  logic       Stall;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NoWrite;
  logic       CondEx;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic [3:0] Flags;

  modport master (
    output Valid, Stall, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    input  CondEx, PCSrc, RegWrite, MemWrite, Flags
  );

  modport slave (
    input  Valid, Stall, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    output CondEx, PCSrc, RegWrite, MemWrite, Flags
  );
endinterface

// File: rtl/cond_unit.sv
// Conditional-execution stage: holds NZCV, evaluates the condition field against it,
// and gates PC/register/memory write strobes so only passing, real, unstalled instructions commit.
module cond_unit (
  input  logic         clk,
  input  logic         reset,
  cond_unit_if.slave   bus
);

  logic [3:0] flags_q;
  logic [3:0] flags_d;
  logic       flag_n;
  logic       flag_z;
  logic       flag_c;
  logic       flag_v;
  logic       cond_ex;
  logic       go;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  // Condition is judged against the stored flags, never this cycle's ALU result.
  always_comb begin
    cond_ex = 1'b0;
    unique case (bus.Cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = ~flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = ~flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = ~flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = ~flag_v;
      4'b1000: cond_ex = flag_c & ~flag_z;
      4'b1001: cond_ex = ~flag_c | flag_z;
      4'b1010: cond_ex = ~(flag_n ^ flag_v);
      4'b1011: cond_ex = flag_n ^ flag_v;
      4'b1100: cond_ex = ~flag_z & ~(flag_n ^ flag_v);
      4'b1101: cond_ex = flag_z | (flag_n ^ flag_v);
      4'b1110: cond_ex = 1'b1;
      4'b1111: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

  // Single commit qualifier shared by strobes and flag update, so a stalled or
  // squashed instruction can neither write state nor touch the flags.
  assign go = bus.Valid & ~bus.Stall & ~reset & cond_ex;

  always_comb begin
    flags_d = flags_q;
    if (go) begin
      if (bus.FlagW[1]) flags_d[3:2] = bus.ALUFlags[3:2];
      if (bus.FlagW[0]) flags_d[1:0] = bus.ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) flags_q <= 4'b0000;
    else       flags_q <= flags_d;
  end

  assign bus.CondEx   = cond_ex;
  assign bus.PCSrc    = bus.PCS & go;
  assign bus.RegWrite = bus.RegW & ~bus.NoWrite & go;
  assign bus.MemWrite = bus.MemW & go;
  assign bus.Flags    = flags_q;

endmodule

// File: doc/cond_unit.md
# cond_unit

Conditional-execution and status-flag stage placed directly downstream of the ALU in the ARM datapath. Holds the architectural NZCV flags register, updates it from the ALU's 4-bit flag output under instruction control, and evaluates the instruction's 4-bit condition field against the stored flags. It gates the register-write, memory-write and PC-write strobes so that only instructions whose condition passes commit side effects. Pipeline bubbles and stalls are handled so flags are never updated twice or by a squashed instruction.

## Interface

Parameters:
- none; all widths are fixed by the ISA.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears flags register
- Valid  in  1  instruction present in the execute stage is real (0 = bubble)
- Stall  in  1  execute stage held this cycle; freezes flags, suppresses strobes
- Cond  in  4  instruction condition field, bits [31:28]
- ALUFlags  in  4  ALU flags {N,Z,C,V}, valid in the same cycle as Cond
- FlagW  in  2  flag write enables: [1] updates N,Z; [0] updates C,V
- PCS  in  1  instruction writes PC (branch or Rd = R15)
- RegW  in  1  instruction writes the register file
- MemW  in  1  instruction writes memory
- NoWrite  in  1  compare-type instruction (CMP/CMN/TST/TEQ); suppresses register write
- CondEx  out  1  condition passed for the current instruction
- PCSrc  out  1  gated PC write
- RegWrite  out  1  gated register-file write
- MemWrite  out  1  gated memory write
- Flags  out  4  current architectural flags {N,Z,C,V}

## Operation

- Flags register: 4 bits, {N,Z,C,V}, bit 3 = N, bit 0 = V.
- CondEx is combinational from Cond and the stored Flags (not ALUFlags):
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V
  - 1000 HI C & ~Z; 1001 LS ~C | Z; 1010 GE N == V; 1011 LT N != V; 1100 GT ~Z & (N == V); 1101 LE Z | (N != V)
  - 1110 AL 1; 1111 reserved, CondEx = 0
- Commit qualifier: Go = Valid & ~Stall & ~reset & CondEx.
- Strobes (combinational): PCSrc = PCS & Go; RegWrite = RegW & ~NoWrite & Go; MemWrite = MemW & Go.
- Flag update on rising clk:
  - reset = 1: Flags <= 4'b0000 (overrides everything).
  - else if Go: Flags[3:2] <= ALUFlags[3:2] when FlagW[1]; Flags[1:0] <= ALUFlags[1:0] when FlagW[0]; unenabled pairs hold.
  - else Flags hold.
- A failed condition never alters flags, even with FlagW set.
- FlagW halves are independent: logical ops with S set use FlagW = 10, leaving C,V intact.

## Timing

- Reset values: Flags = 0000; during reset cycles PCSrc, RegWrite, MemWrite = 0; CondEx reflects Cond against 0000 (e.g. EQ fails, NE passes).
- Strobe latency: 0 cycles; outputs valid in the same cycle as inputs, before the edge.
- Flag latency: 1 cycle; an instruction's flags are visible to the instruction evaluated in the next cycle, not the same one.
- Back-to-back: CMP in cycle n then BEQ in cycle n+1 sees CMP's flags.
- Stall: with Stall = 1 for k cycles, flags update exactly once, in the first cycle Stall = 0 and Valid = 1.
- Bubble (Valid = 0): no strobes, no flag update, regardless of Cond/FlagW.
- reset asserted mid-stream: next edge clears Flags; strobes are 0 in that same cycle.
- Simultaneous FlagW = 11 and condition pass: all four flags replaced atomically on one edge.

## Test plan

- Reset: hold reset 2 cycles with Valid = 1, Cond = 1110, RegW = 1 -> RegWrite = 0, Flags = 0000; release -> RegWrite = 1 in the same cycle.
- Compare then branch: cycle 0 Cond = 1110, FlagW = 11, NoWrite = 1, RegW = 1, ALUFlags = 0100 -> RegWrite = 0, Flags = 0100 after edge; cycle 1 Cond = 0000, PCS = 1 -> PCSrc = 1; with Cond = 0001 -> PCSrc = 0.
- Partial update: Flags = 0011, FlagW = 10, ALUFlags = 1000, Cond = 1110 -> Flags = 1011 after edge.
- Failed condition: Flags = 0100, Cond = 0001, FlagW = 11, MemW = 1, ALUFlags = 1111 -> MemWrite = 0, Flags stay 0100.
- Signed compares: sweep all 16 {N,Z,C,V} values x all 16 Cond codes -> CondEx matches the table; 1111 always 0.
- Stall/bubble: Stall = 1 for 3 cycles with FlagW = 11, ALUFlags = 0010 -> Flags unchanged, strobes 0; Stall drops -> one update, Flags = 0010; then Valid = 0 with ALUFlags = 1000 -> Flags stay 0010.
